// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory load/store unit.
package data_mem_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 4;
  localparam int WAIT_W = 3;

  // The memory writes whenever its read line is low, so the write level
  // must only ever appear while a store access is in progress.
  localparam logic MEM_READ  = 1'b1;
  localparam logic MEM_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    WDATA,
    ACCESS,
    DONE
  } state_t;

endpackage

// File: rtl/data_mem_lsu_wait_ctr.sv
// Loadable down-counter that times the wait states of one memory access.
module lsu_wait_ctr #(
  parameter int WIDTH = data_mem_pkg::WAIT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] value_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Load wins over decrement; the count parks at zero once it gets there.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store initiator between the execute stage and the 256x16 data memory.
module data_mem_lsu #(
  parameter int ADDR_W      = data_mem_pkg::ADDR_W,
  parameter int DATA_W      = data_mem_pkg::DATA_W,
  parameter int LEN_W       = data_mem_pkg::LEN_W,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wdata_valid,
  output logic              wdata_ready,
  input  logic [DATA_W-1:0] wdata,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  import data_mem_pkg::*;

  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] curAddr_q, curAddr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  beatCnt_q, beatCnt_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rdataValid_q, rdataValid_d;

  logic waitZero;
  logic waitLoad;
  logic waitDec;
  logic accessLast;
  logic lastBeat;

  assign accessLast = (state_q == ACCESS) && waitZero;
  assign lastBeat   = (beatCnt_q == len_q);

  // Reload the wait counter on every entry into ACCESS, including beat-to-beat
  // re-entry on a load burst, so each beat gets the full set of wait states.
  assign waitLoad = (state_d == ACCESS) && ((state_q != ACCESS) || accessLast);
  assign waitDec  = (state_q == ACCESS);

  lsu_wait_ctr #(
    .WIDTH(WAIT_W)
  ) u_wait_ctr (
    .clk    (clk),
    .rst    (rst),
    .load_i (waitLoad),
    .value_i(WAIT_LOAD),
    .dec_i  (waitDec),
    .zero_o (waitZero)
  );

  // State register; reset discards any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: stores go through WDATA before every beat, loads
  // chain ACCESS beats back to back until the last one.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = req_we ? WDATA : ACCESS;
        end
      end
      WDATA: begin
        if (wdata_valid) begin
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (accessLast) begin
          if (lastBeat) begin
            state_d = DONE;
          end else if (we_q) begin
            state_d = WDATA;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath next values: request capture, store-data capture, and the
  // per-beat address/count advance and load-data capture.
  always_comb begin
    curAddr_d    = curAddr_q;
    len_d        = len_q;
    beatCnt_d    = beatCnt_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    rdataValid_d = 1'b0;
    if ((state_q == IDLE) && req_valid) begin
      curAddr_d = req_addr;
      len_d     = req_len;
      we_d      = req_we;
      beatCnt_d = '0;
    end
    if ((state_q == WDATA) && wdata_valid) begin
      wdata_d = wdata;
    end
    if (accessLast) begin
      if (!we_q) begin
        rdata_d      = mem_rdata;
        rdataValid_d = 1'b1;
      end
      if (!lastBeat) begin
        curAddr_d = curAddr_q + 1'b1;
        beatCnt_d = beatCnt_q + 1'b1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      curAddr_q    <= '0;
      len_q        <= '0;
      beatCnt_q    <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      rdataValid_q <= 1'b0;
    end else begin
      curAddr_q    <= curAddr_d;
      len_q        <= len_d;
      beatCnt_q    <= beatCnt_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      rdataValid_q <= rdataValid_d;
    end
  end

  // Handshake, status and memory control decoded from the current state;
  // the write level is only driven during a store ACCESS.
  always_comb begin
    req_ready   = 1'b0;
    wdata_ready = 1'b0;
    done        = 1'b0;
    busy        = 1'b1;
    mem_en      = 1'b0;
    mem_read    = MEM_READ;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      WDATA: begin
        wdata_ready = 1'b1;
      end
      ACCESS: begin
        mem_en   = 1'b1;
        mem_read = we_q ? MEM_WRITE : MEM_READ;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  assign mem_addr    = curAddr_q;
  assign mem_wdata   = wdata_q;
  assign rdata       = rdata_q;
  assign rdata_valid = rdataValid_q;

endmodule
